// File: rtl/branch_cmp_pkg.sv
// rtl/branch_cmp_pkg.sv - shared types and defaults for the sequential branch comparator
package branch_cmp_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int CHUNK_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the chunk index register; never narrower than one bit
    function automatic int idx_width(input int n_chunks);
        return (n_chunks > 1) ? $clog2(n_chunks) : 1;
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational unsigned comparator built as a recursive halving tree
module chunk_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_equal,
    output logic         o_less
);

    generate
        if (W == 1) begin : g_leaf
            // Single bit: a<b only when a=0 and b=1
            assign o_equal = (i_a[0] == i_b[0]);
            assign o_less  = ~i_a[0] & i_b[0];
        end else begin : g_node
            localparam int HI_W = W / 2;
            localparam int LO_W = W - HI_W;

            logic w_hi_eq;
            logic w_hi_lt;
            logic w_lo_eq;
            logic w_lo_lt;

            chunk_cmp #(.W(HI_W)) u_hi (
                .i_a     (i_a[W-1 -: HI_W]),
                .i_b     (i_b[W-1 -: HI_W]),
                .o_equal (w_hi_eq),
                .o_less  (w_hi_lt)
            );

            chunk_cmp #(.W(LO_W)) u_lo (
                .i_a     (i_a[LO_W-1:0]),
                .i_b     (i_b[LO_W-1:0]),
                .o_equal (w_lo_eq),
                .o_less  (w_lo_lt)
            );

            // Upper half decides unless it is equal, then the lower half decides
            assign o_equal = w_hi_eq & w_lo_eq;
            assign o_less  = w_hi_lt | (w_hi_eq & w_lo_lt);
        end
    endgenerate

endmodule

// File: rtl/branch_cmp_seq.sv
// rtl/branch_cmp_seq.sv - chunk-serial signed/unsigned comparator; BRANCH_CMP_EARLY_EXIT_EN stops at first unequal chunk
module branch_cmp_seq
    import branch_cmp_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_unsigned,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_equal,
    output logic              o_less,
    output logic              o_busy
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [DATA_W-1:0] SIGN_MASK = DATA_W'(1) << (DATA_W - 1);

    generate
        if (CHUNK_W < 1 || (CHUNK_W & (CHUNK_W - 1)) != 0 || (DATA_W % CHUNK_W) != 0) begin : g_bad_cfg
            $error("branch_cmp_seq: CHUNK_W must be a power of two dividing DATA_W");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [IDX_W-1:0]   r_idx;
    // Chunk result is registered before the FSM acts on it, so each
    // decision lands one cycle after its chunk is compared (n+1 latency)
    logic               r_pipe_vld;
    logic               r_pipe_eq;
    logic               r_pipe_lt;
    logic               r_pipe_last;
    logic               r_equal;
    logic               r_less;

    logic [CHUNK_W-1:0] w_ch_a;
    logic [CHUNK_W-1:0] w_ch_b;
    logic               w_ch_eq;
    logic               w_ch_lt;
    logic               w_accept;
    logic               w_eval;
    logic               w_finish;
    logic               w_res_eq;
    logic               w_res_lt;

    assign w_ch_a   = r_a[r_idx*CHUNK_W +: CHUNK_W];
    assign w_ch_b   = r_b[r_idx*CHUNK_W +: CHUNK_W];
    assign w_accept = (r_state == IDLE) & i_valid & ~i_reset;
    assign w_eval   = (r_state == RUN) & r_pipe_vld;

    chunk_cmp #(.W(CHUNK_W)) u_chunk_cmp (
        .i_a     (w_ch_a),
        .i_b     (w_ch_b),
        .o_equal (w_ch_eq),
        .o_less  (w_ch_lt)
    );

`ifdef BRANCH_CMP_EARLY_EXIT_EN
    assign w_finish = w_eval & (~r_pipe_eq | r_pipe_last);
    assign w_res_eq = r_pipe_eq;
    assign w_res_lt = r_pipe_lt;
`else
    logic r_found;
    logic r_found_lt;

    // Constant time: always scan to chunk 0, but the first difference wins
    assign w_finish = w_eval & r_pipe_last;
    assign w_res_eq = ~r_found & r_pipe_eq;
    assign w_res_lt = r_found ? r_found_lt : r_pipe_lt;

    // Remember the most significant unequal chunk seen so far
    always_ff @(posedge i_clk) begin
        if (i_reset || w_accept) begin
            r_found    <= 1'b0;
            r_found_lt <= 1'b0;
        end else if (w_eval && !r_pipe_eq && !r_found) begin
            r_found    <= 1'b1;
            r_found_lt <= r_pipe_lt;
        end
    end
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (w_finish) w_next = DONE;
            DONE:    if (i_ready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand latch, chunk scan and result capture
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_pipe_vld  <= 1'b0;
            r_pipe_eq   <= 1'b0;
            r_pipe_lt   <= 1'b0;
            r_pipe_last <= 1'b0;
            r_equal     <= 1'b0;
            r_less      <= 1'b0;
        end else if (w_accept) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order
            r_a         <= i_unsigned ? i_a : (i_a ^ SIGN_MASK);
            r_b         <= i_unsigned ? i_b : (i_b ^ SIGN_MASK);
            r_idx       <= IDX_W'(NCHUNK - 1);
            r_pipe_vld  <= 1'b0;
            r_pipe_last <= 1'b0;
            r_equal     <= 1'b0;
            r_less      <= 1'b0;
        end else if (r_state == RUN) begin
            r_pipe_vld  <= 1'b1;
            r_pipe_eq   <= w_ch_eq;
            r_pipe_lt   <= w_ch_lt;
            r_pipe_last <= (r_idx == '0);
            if (r_idx != '0) r_idx <= r_idx - 1'b1;
            if (w_finish) begin
                r_equal <= w_res_eq;
                r_less  <= w_res_lt & ~w_res_eq;
            end
        end
    end

    // Outputs, forced low while reset is asserted
    always_comb begin
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_valid = 1'b0;
        o_equal = 1'b0;
        o_less  = 1'b0;
        if (!i_reset) begin
            o_ready = (r_state == IDLE);
            o_busy  = (r_state != IDLE);
            o_valid = (r_state == DONE);
            o_equal = (r_state == DONE) & r_equal;
            o_less  = (r_state == DONE) & r_less;
        end
    end

endmodule

// File: tb/tb_branch_cmp_seq.sv
// tb/tb_branch_cmp_seq.sv - directed table-driven bench for branch_cmp_seq
module tb_branch_cmp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic        out_valid;
    logic        in_ready;
    logic        eq;
    logic        lt;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_cmp_seq #(.DATA_W(32), .CHUNK_W(8)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_valid    (in_valid),
        .o_ready    (out_ready),
        .i_a        (a),
        .i_b        (b),
        .i_unsigned (uns),
        .o_valid    (out_valid),
        .i_ready    (in_ready),
        .o_equal    (eq),
        .o_less     (lt),
        .o_busy     (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        uns;
        logic        eq;
        logic        lt;
        int          n;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int n);
`ifdef BRANCH_CMP_EARLY_EXIT_EN
        return n + 1;
`else
        return 5;
`endif
    endfunction

    // Issue one request and measure edges from the accepting edge to o_valid
    task automatic run_cmp(input logic [31:0] va, input logic [31:0] vb, input logic vu,
                           output int lat, output logic r_eq, output logic r_lt);
        int wait_cnt;
        wait_cnt = 0;
        while (!out_ready && wait_cnt < 20) begin
            @(posedge clk); #1; wait_cnt++;
        end
        a = va; b = vb; uns = vu; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; uns = $urandom_range(0, 1);
        check("busy_after_accept", int'(busy), 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        r_eq = eq;
        r_lt = lt;
    endtask

    task automatic handshake();
        in_ready = 1'b1;
        @(posedge clk); #1;
        in_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        logic r_eq;
        logic r_lt;

        vecs[0]  = '{32'h12345678, 32'h12345678, 1'b1, 1'b1, 1'b0, 4};
        vecs[1]  = '{32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b1, 1};
        vecs[2]  = '{32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1};
        vecs[4]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
        vecs[5]  = '{32'h000000FE, 32'h000000FF, 1'b1, 1'b0, 1'b1, 4};
        vecs[6]  = '{32'h12340000, 32'h12FF0000, 1'b1, 1'b0, 1'b1, 2};
        vecs[7]  = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1};
        vecs[8]  = '{32'hFFFFFF00, 32'hFFFFFF80, 1'b0, 1'b0, 1'b1, 4};
        vecs[9]  = '{32'h00010000, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 2};
        vecs[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 4};

        rst = 1'b1; in_valid = 1'b1; in_ready = 1'b0; a = '0; b = '0; uns = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(out_ready), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy",  int'(busy), 0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("idle_ready", int'(out_ready), 1);

        for (int i = 0; i < 11; i++) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].uns, lat, r_eq, r_lt);
            check($sformatf("v%0d_lat", i),  lat, exp_lat(vecs[i].n));
            check($sformatf("v%0d_eq", i),   int'(r_eq), int'(vecs[i].eq));
            check($sformatf("v%0d_less", i), int'(r_lt), int'(vecs[i].lt));
            handshake();
            check($sformatf("v%0d_idle", i), int'(out_ready), 1);
        end

        // Result held under back-pressure while requests are offered
        run_cmp(32'h00000001, 32'h80000000, 1'b1, lat, r_eq, r_lt);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check("hold_valid", int'(out_valid), 1);
            check("hold_less",  int'(lt), 1);
            check("hold_equal", int'(eq), 0);
            check("hold_ready", int'(out_ready), 0);
        end
        in_valid = 1'b0;
        handshake();
        check("hold_ret_ready", int'(out_ready), 1);
        check("hold_ret_valid", int'(out_valid), 0);
        check("hold_ret_busy",  int'(busy), 0);

        // Reset during the second RUN cycle discards the compare
        a = 32'h12345678; b = 32'h12345678; uns = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  int'(busy), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", int'(out_ready), 1);
        check("post_rst_busy",  int'(busy), 0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("post_rst_no_valid", seen, 0);
        end
        run_cmp(32'hFFFFFFFF, 32'h00000000, 1'b0, lat, r_eq, r_lt);
        check("post_rst_lat",  lat, exp_lat(1));
        check("post_rst_less", int'(r_lt), 1);
        check("post_rst_eq",   int'(r_eq), 0);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_cmp_seq.md
BRANCH_CMP_SEQ -- requirements
Module: branch_cmp_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand width.
REQ-002 The block SHALL have parameter CHUNK_W, default 8, giving the bits compared per cycle; it must be a power of two and DATA_W % CHUNK_W == 0, else elaboration error.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_valid, input, 1 bit: a compare request is present.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have ports i_a and i_b, inputs, DATA_W bits each: the operands.
REQ-008 The block SHALL have port i_unsigned, input, 1 bit: 1 selects unsigned compare, 0 selects two's-complement compare.
REQ-009 The block SHALL have port o_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port i_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have ports o_equal and o_less, outputs, 1 bit each: a==b and a<b.
REQ-012 The block SHALL have port o_busy, output, 1 bit: the block is not in IDLE.

Function
REQ-013 The block SHALL use FSM states IDLE, RUN and DONE.
REQ-014 o_ready SHALL equal 1 only in IDLE with i_reset low; a request is accepted on a rising edge where i_valid & o_ready.
REQ-015 On acceptance, the block SHALL latch the operands; for a signed compare it SHALL invert bit DATA_W-1 of both latched operands; it SHALL load chunk index idx = DATA_W/CHUNK_W-1 and go to RUN.
REQ-016 In RUN, each cycle SHALL compare chunk idx (MSB chunk first) with the CHUNK_W-wide sub-comparator.
REQ-017 If a chunk is unequal in RUN, the block SHALL register less = sub-comparator less and equal = 0, then go to DONE.
REQ-018 If chunk idx==0 is equal in RUN, the block SHALL register equal=1 and less=0, then go to DONE; otherwise it SHALL decrement idx and stay in RUN.
REQ-019 Latency: with n chunks examined (1..DATA_W/CHUNK_W), o_valid SHALL rise n+1 cycles after the accepting edge.
REQ-020 In DONE, o_valid SHALL be 1, and o_equal and o_less SHALL be held stable until the edge where i_ready=1; that edge returns the FSM to IDLE.
REQ-021 The block SHALL NOT allow a same-cycle restart; a new request can be accepted at the earliest one cycle after the result handshake.
REQ-022 i_valid SHALL be ignored outside IDLE; operand inputs SHALL be don't-care after acceptance.
REQ-023 Outside DONE, o_valid, o_equal and o_less SHALL be 0.

Reset
REQ-024 When i_reset=1 at a rising edge, the block SHALL go to IDLE and clear idx, the latched operands and the result registers, in any state including mid-RUN and DONE.
REQ-025 While i_reset=1, o_ready, o_valid, o_equal, o_less and o_busy SHALL be 0; a discarded in-flight compare produces no result.

Configuration
REQ-026 With macro BRANCH_CMP_EARLY_EXIT_EN defined, the block SHALL terminate on the first unequal chunk as in REQ-017.
REQ-027 Without BRANCH_CMP_EARLY_EXIT_EN, the block SHALL latch the result of the first unequal chunk but keep scanning down to idx==0, giving fixed latency DATA_W/CHUNK_W+1 (constant-time); results SHALL be identical in both builds.

Structure
REQ-028 Package branch_cmp_pkg SHALL hold the state enum type (IDLE/RUN/DONE) and default localparams DATA_W_DEF=32 and CHUNK_W_DEF=8.
REQ-029 Sub-module chunk_cmp SHALL be a purely combinational CHUNK_W-bit unsigned comparator with outputs equal and less, built as a recursive halving tree; it is instantiated once.
REQ-030 The idx width SHALL be $clog2(DATA_W/CHUNK_W), minimum 1.

Verification (DATA_W=32, CHUNK_W=8, early exit on unless stated)
REQ-031 Test: a=0x12345678, b=0x12345678, unsigned -> o_equal=1, o_less=0, o_valid 5 cycles after accept.
REQ-032 Test: a=0x00000001, b=0x80000000 -> unsigned: o_less=1 with o_valid 2 cycles after accept; signed: o_less=0, o_equal=0.
REQ-033 Test: a=0xFFFFFFFF, b=0x00000000, signed -> o_less=1; unsigned -> o_less=0; a=0x000000FE, b=0x000000FF unsigned -> o_less=1 after 4 chunks.
REQ-034 Test: hold i_ready=0 for 5 cycles in DONE while pulsing i_valid -> o_valid and the result stay stable, o_ready=0, no request accepted; i_ready=1 -> IDLE next cycle.
REQ-035 Test: assert i_reset during the 2nd RUN cycle -> IDLE on the next edge, all outputs 0, no o_valid; after release o_ready=1 and the next compare is correct.
REQ-036 Test: without BRANCH_CMP_EARLY_EXIT_EN, repeat REQ-032 -> same result, o_valid exactly 5 cycles after accept.
